// File: rtl/timer_bank.sv
// timer_bank: prescaled free-running COUNT plus CHANNELS down-counting timer channels on the
// valid/ready CPU bus. Define TIMER_PWM_EN to add per-channel COMPARE registers and PWM outputs.
module timer_bank #(
    parameter int CLK_HZ   = 20000000,
    parameter int TICK_HZ  = 1000000,
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          addr,
    input  logic [31:0]         din,
    input  logic [3:0]          lane,
    input  logic                wr,
    input  logic                valid,
    output logic                ready,
    output logic [31:0]         dout,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any,
    output logic [CHANNELS-1:0] pwm
);
    localparam logic [15:0] PRESCALE_RST = 16'(CLK_HZ / TICK_HZ - 1);

    logic                ready_q, ready_d;
    logic [31:0]         dout_q, dout_d;
    logic [CHANNELS-1:0] irq_q, irq_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [CHANNELS-1:0] status_q, status_d;
    logic [CHANNELS-1:0] enable_q, enable_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [15:0]         div_q, div_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] per_q, per_d;
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    logic [WIDTH-1:0]    value_q  [CHANNELS];
    logic [WIDTH-1:0]    value_d  [CHANNELS];
`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0]    compare_q [CHANNELS];
    logic [WIDTH-1:0]    compare_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
`endif

    logic                accept, do_wr, tick;
    logic [3:0]          ch_sel;
    logic [31:0]         wmask, rdata;
    logic [CHANNELS-1:0] set_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    assign accept = valid & ~ready_q;
    assign do_wr  = accept & wr;
    assign tick   = (div_q == prescale_q);
    assign wmask  = {{8{lane[3]}}, {8{lane[2]}}, {8{lane[1]}}, {8{lane[0]}}};
    // Channel index of word offsets 4.. ; offsets 0..3 map to 15, which never matches a channel.
    assign ch_sel = addr[5:2] - 4'd1;

    always_comb begin
        rdata = '1;
        case (addr)
            6'd0: rdata = 32'(count_q);
            6'd1: rdata = 32'(status_q);
            6'd2: rdata = 32'(enable_q);
            6'd3: rdata = {16'd0, prescale_q};
            default: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (ch_sel == 4'(n)) begin
                        case (addr[1:0])
                            2'd0:    rdata = {30'd0, per_q[n], en_q[n]};
                            2'd1:    rdata = 32'(reload_q[n]);
                            2'd2:    rdata = 32'(value_q[n]);
`ifdef TIMER_PWM_EN
                            default: rdata = 32'(compare_q[n]);
`else
                            default: rdata = '0;
`endif
                        endcase
                    end
                end
            end
        endcase
    end

    // Tick effects are applied first; a CPU write to the same register then overrides them.
    always_comb begin
        ready_d    = accept;
        dout_d     = accept ? rdata : dout_q;
        irq_d      = status_q & enable_q;
        div_d      = tick ? 16'd0 : div_q + 16'd1;
        prescale_d = prescale_q;
        count_d    = tick ? count_q + WIDTH'(1) : count_q;
        enable_d   = enable_q;
        set_bits   = '0;
        en_d       = en_q;
        per_d      = per_q;
        for (int n = 0; n < CHANNELS; n++) begin
            reload_d[n] = reload_q[n];
            value_d[n]  = value_q[n];
`ifdef TIMER_PWM_EN
            compare_d[n] = compare_q[n];
            pwm_d[n]     = en_q[n] & (value_q[n] < compare_q[n]);
`endif
            if (tick && en_q[n]) begin
                if (value_q[n] != '0) begin
                    value_d[n] = value_q[n] - WIDTH'(1);
                end else begin
                    set_bits[n] = 1'b1;
                    if (per_q[n]) value_d[n] = reload_q[n];
                    else          en_d[n]    = 1'b0;
                end
            end
            if (do_wr && ch_sel == 4'(n)) begin
                case (addr[1:0])
                    2'd0: begin
                        if (lane[0]) begin
                            en_d[n]  = din[0];
                            per_d[n] = din[1];
                        end
                    end
                    2'd1: reload_d[n] = WIDTH'(merge(32'(reload_q[n]), din, wmask));
                    2'd2: value_d[n]  = WIDTH'(merge(32'(value_q[n]), din, wmask));
`ifdef TIMER_PWM_EN
                    2'd3: compare_d[n] = WIDTH'(merge(32'(compare_q[n]), din, wmask));
`endif
                    default: ;
                endcase
            end
        end
        status_d = status_q;
        if (do_wr) begin
            case (addr)
                6'd0: count_d  = WIDTH'(merge(32'(count_q), din, wmask));
                6'd1: status_d = status_q & ~CHANNELS'(din & wmask);
                6'd2: enable_d = CHANNELS'(merge(32'(enable_q), din, wmask));
                6'd3: begin
                    prescale_d = 16'(merge({16'd0, prescale_q}, din, wmask));
                    div_d      = 16'd0;
                end
                default: ;
            endcase
        end
        // An expiry beats a same-cycle write-1-to-clear of that bit.
        status_d = status_d | set_bits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            dout_q     <= '0;
            irq_q      <= '0;
            count_q    <= '0;
            status_q   <= '0;
            enable_q   <= '0;
            prescale_q <= PRESCALE_RST;
            div_q      <= '0;
            en_q       <= '0;
            per_q      <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                reload_q[n] <= '0;
                value_q[n]  <= '0;
`ifdef TIMER_PWM_EN
                compare_q[n] <= '0;
`endif
            end
`ifdef TIMER_PWM_EN
            pwm_q <= '0;
`endif
        end else begin
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            irq_q      <= irq_d;
            count_q    <= count_d;
            status_q   <= status_d;
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            div_q      <= div_d;
            en_q       <= en_d;
            per_q      <= per_d;
            for (int n = 0; n < CHANNELS; n++) begin
                reload_q[n] <= reload_d[n];
                value_q[n]  <= value_d[n];
`ifdef TIMER_PWM_EN
                compare_q[n] <= compare_d[n];
`endif
            end
`ifdef TIMER_PWM_EN
            pwm_q <= pwm_d;
`endif
        end
    end

    assign ready   = ready_q;
    assign dout    = dout_q;
    assign irq     = irq_q;
    assign irq_any = |irq_q;
`ifdef TIMER_PWM_EN
    assign pwm     = pwm_q;
`else
    assign pwm     = '0;
`endif
endmodule
